regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 32×32 register file. It shares the file's single write port among three requesters: 0 = ALU, 1 = load unit, 2 = multiply/divide unit. Each cycle it accepts at most one write through a valid/ready handshake, using round-robin priority. The accepted write is driven into the register file's RegWrite/WriteAddr/WriteData inputs one cycle later, from registered outputs.

---
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file's single write port
// among ALU (0), load unit (1) and mul/div unit (2), with a registered output stage.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic [2:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic [2:0]        req_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic [1:0]        grant_id,
  output logic [7:0]        zero_drops
);

  logic [1:0]        r_ptr;
  logic              r_regWrite;
  logic [ADDR_W-1:0] r_writeAddr;
  logic [DATA_W-1:0] r_writeData;
  logic [1:0]        r_grantId;
  logic [7:0]        r_zeroDrops;

  logic              w_any;
  logic [1:0]        w_gid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // Reset gates the grant so no requester sees ready while reset is asserted.
  assign w_any = reset & ~hold & (|req_valid);

  always_comb begin
    w_gid = 2'd0;
    case (r_ptr)
      2'd1: begin
        if (req_valid[1])      w_gid = 2'd1;
        else if (req_valid[2]) w_gid = 2'd2;
        else                   w_gid = 2'd0;
      end
      2'd2: begin
        if (req_valid[2])      w_gid = 2'd2;
        else if (req_valid[0]) w_gid = 2'd0;
        else                   w_gid = 2'd1;
      end
      default: begin
        if (req_valid[0])      w_gid = 2'd0;
        else if (req_valid[1]) w_gid = 2'd1;
        else                   w_gid = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_addr = req_addr0;
    w_data = req_data0;
    case (w_gid)
      2'd1: begin
        w_addr = req_addr1;
        w_data = req_data1;
      end
      2'd2: begin
        w_addr = req_addr2;
        w_data = req_data2;
      end
      default: begin
        w_addr = req_addr0;
        w_data = req_data0;
      end
    endcase
  end

  assign req_ready = w_any ? (3'b001 << w_gid) : 3'b000;

  // Writes to $zero are accepted but only counted, never committed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr       <= 2'd0;
      r_regWrite  <= 1'b0;
      r_writeAddr <= '0;
      r_writeData <= '0;
      r_grantId   <= 2'd0;
      r_zeroDrops <= 8'd0;
    end else begin
      r_regWrite <= 1'b0;
      if (w_any) begin
        r_ptr <= (w_gid == 2'd2) ? 2'd0 : w_gid + 2'd1;
        if (w_addr != '0) begin
          r_regWrite  <= 1'b1;
          r_writeAddr <= w_addr;
          r_writeData <= w_data;
          r_grantId   <= w_gid;
        end else if (r_zeroDrops != 8'hFF) begin
          r_zeroDrops <= r_zeroDrops + 8'd1;
        end
      end
    end
  end

  assign RegWrite   = r_regWrite;
  assign WriteAddr  = r_writeAddr;
  assign WriteData  = r_writeData;
  assign grant_id   = r_grantId;
  assign zero_drops = r_zeroDrops;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected output-stage values are queued
// when a cycle is driven and compared when the registered outputs appear.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [4:0]  req_addr0, req_addr1, req_addr2;
  logic [31:0] req_data0, req_data1, req_data2;
  logic [2:0]  req_ready;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [1:0]  grant_id;
  logic [7:0]  zero_drops;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  gid;
    logic [7:0]  zd;
  } exp_t;

  exp_t        expQ[$];
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic [1:0]  mGid;
  logic [7:0]  mZd;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
    .req_ready(req_ready), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .grant_id(grant_id), .zero_drops(zero_drops)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mAddr = '0;
    mData = '0;
    mGid  = '0;
    mZd   = '0;
    expQ.delete();
    expQ.push_back('{we: 1'b0, addr: 5'd0, data: 32'd0, gid: 2'd0, zd: 8'd0});
  endtask

  // Compares the registered outputs against the oldest queued expectation.
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      check("RegWrite", {31'd0, RegWrite}, {31'd0, e.we});
      check("WriteAddr", {27'd0, WriteAddr}, {27'd0, e.addr});
      check("WriteData", WriteData, e.data);
      check("grant_id", {30'd0, grant_id}, {30'd0, e.gid});
      check("zero_drops", {24'd0, zero_drops}, {24'd0, e.zd});
    end
  endtask

  // Drives one cycle, checks ready mid-cycle and queues the expected commit.
  task automatic applyStimulus(input logic [2:0] v, input logic h, input logic [2:0] expReady);
    exp_t        e;
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  g;
    req_valid = v;
    hold      = h;
    @(negedge clock);
    checkOutput();
    check("req_ready", {29'd0, req_ready}, {29'd0, expReady});
    e = '{we: 1'b0, addr: mAddr, data: mData, gid: mGid, zd: mZd};
    if (expReady != 3'b000) begin
      g = expReady[2] ? 2'd2 : (expReady[1] ? 2'd1 : 2'd0);
      a = (g == 2'd2) ? req_addr2 : ((g == 2'd1) ? req_addr1 : req_addr0);
      d = (g == 2'd2) ? req_data2 : ((g == 2'd1) ? req_data1 : req_data0);
      if (a != 5'd0) begin
        mAddr = a;
        mData = d;
        mGid  = g;
        e = '{we: 1'b1, addr: a, data: d, gid: g, zd: mZd};
      end else begin
        if (mZd != 8'hFF) mZd = mZd + 8'd1;
        e.zd = mZd;
      end
    end
    expQ.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    hold = 1'b0;
    req_valid = 3'b000;
    req_addr0 = 5'd1;  req_data0 = 32'h1111_0000;
    req_addr1 = 5'd2;  req_data1 = 32'h2222_0000;
    req_addr2 = 5'd3;  req_data2 = 32'h3333_0000;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_ready", {29'd0, req_ready}, 32'd0);
    reset = 1'b1;
    resetModel();

    $display("[TB] round-robin with all requesters valid");
    applyStimulus(3'b111, 1'b0, 3'b001);
    applyStimulus(3'b111, 1'b0, 3'b010);
    applyStimulus(3'b111, 1'b0, 3'b100);
    applyStimulus(3'b111, 1'b0, 3'b001);
    applyStimulus(3'b111, 1'b0, 3'b010);
    applyStimulus(3'b111, 1'b0, 3'b100);
    applyStimulus(3'b000, 1'b0, 3'b000);

    $display("[TB] single requester 2");
    req_addr2 = 5'd7;
    req_data2 = 32'hDEAD_BEEF;
    applyStimulus(3'b100, 1'b0, 3'b100);
    applyStimulus(3'b000, 1'b0, 3'b000);

    $display("[TB] hold blocks grants");
    for (int i = 0; i < 4; i++) applyStimulus(3'b011, 1'b1, 3'b000);
    applyStimulus(3'b011, 1'b0, 3'b001);

    $display("[TB] lost arbitration");
    applyStimulus(3'b101, 1'b0, 3'b100);
    applyStimulus(3'b001, 1'b0, 3'b001);

    $display("[TB] writes to zero register");
    req_addr1 = 5'd0;
    req_data1 = 32'hBAD0_BAD0;
    for (int i = 0; i < 300; i++) applyStimulus(3'b010, 1'b0, 3'b010);
    applyStimulus(3'b000, 1'b0, 3'b000);
    check("zero_drops_saturated", {24'd0, zero_drops}, 32'd255);

    $display("[TB] reset with a write in the output stage");
    req_addr0 = 5'd4;  req_data0 = 32'h4444_0004;
    req_addr1 = 5'd5;  req_data1 = 32'h5555_0005;
    req_addr2 = 5'd6;  req_data2 = 32'h6666_0006;
    applyStimulus(3'b111, 1'b0, 3'b100);
    checkOutput();
    #2;
    reset = 1'b0;
    #1;
    check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    check("rst_WriteAddr", {27'd0, WriteAddr}, 32'd0);
    check("rst_WriteData", WriteData, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_zero_drops", {24'd0, zero_drops}, 32'd0);
    check("rst_ready", {29'd0, req_ready}, 32'd0);
    req_valid = 3'b000;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    resetModel();
    applyStimulus(3'b111, 1'b0, 3'b001);
    applyStimulus(3'b000, 1'b0, 3'b000);
    @(negedge clock);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
